// File: rtl/ysyx_23060191_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one radix-2 step per cycle, valid/ready on both sides, flush for squash.
module ysyx_23060191_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic             r_neg;
  logic             r_fast;
  logic [WIDTH-1:0] r_opnd;
  logic [W2-1:0]    r_prod;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_res;

  logic             w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic             w_b_zero, w_ovf, w_fast, w_neg_res;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_fast_res;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_add, w_trial;
  logic [W2-1:0]    w_mul_next, w_div_next, w_prod_s;
  logic [WIDTH-1:0] w_q, w_r, w_final;

  assign in_ready  = !rst && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;

  // Request decode: operand magnitudes, result sign, and the one-step special cases
  always_comb begin
    w_a_sgn   = (in_op == OP_MULH) || (in_op == OP_MULHSU) || (in_op == OP_DIV) || (in_op == OP_REM);
    w_b_sgn   = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
    w_a_neg   = w_a_sgn && in_a[WIDTH-1];
    w_b_neg   = w_b_sgn && in_b[WIDTH-1];
    w_a_mag   = w_a_neg ? -in_a : in_a;
    w_b_mag   = w_b_neg ? -in_b : in_b;
    w_b_zero  = (in_b == '0);
    w_ovf     = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_a == MIN_VAL) && (&in_b);
    w_fast    = in_op[2] && (w_b_zero || w_ovf);
    w_neg_res = (in_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    if (w_b_zero) begin
      w_fast_res = in_op[1] ? in_a : '1;
    end else begin
      w_fast_res = in_op[1] ? '0 : MIN_VAL;
    end
  end

  // One iteration of each algorithm plus the final sign fix-up and result select
  always_comb begin
    w_addend   = r_prod[0] ? r_opnd : '0;
    w_add      = {1'b0, r_prod[W2-1:WIDTH]} + {1'b0, w_addend};
    w_mul_next = {w_add, r_prod[WIDTH-1:1]};
    w_trial    = r_prod[W2-1:WIDTH-1] - {1'b0, r_opnd};
    w_div_next = w_trial[WIDTH] ? {r_prod[W2-2:0], 1'b0}
                                : {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
    w_prod_s   = r_neg ? -r_prod : r_prod;
    w_q        = r_neg ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    w_r        = r_neg ? -r_prod[W2-1:WIDTH] : r_prod[W2-1:WIDTH];
    w_final    = '0;
    if (r_fast) begin
      w_final = r_prod[WIDTH-1:0];
    end else begin
      case (r_op)
        OP_MUL:                       w_final = w_prod_s[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_s[W2-1:WIDTH];
        OP_DIV, OP_DIVU:              w_final = w_q;
        OP_REM, OP_REMU:              w_final = w_r;
        default:                      w_final = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_fast      <= 1'b0;
      r_opnd      <= '0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_CALC;
            r_op    <= in_op;
            r_neg   <= w_neg_res;
            r_fast  <= w_fast;
            if (w_fast) begin
              // Special result parked in the product register; finalised next edge
              r_cnt  <= '0;
              r_opnd <= '0;
              r_prod <= {{WIDTH{1'b0}}, w_fast_res};
            end else if (in_op[2]) begin
              r_cnt  <= CW'(WIDTH);
              r_opnd <= w_b_mag;
              r_prod <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_cnt  <= CW'(WIDTH);
              r_opnd <= w_a_mag;
              r_prod <= {{WIDTH{1'b0}}, w_b_mag};
            end
          end
        end
        S_CALC: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CW'(1);
            r_prod <= r_op[2] ? w_div_next : w_mul_next;
          end else begin
            r_out_res   <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
